// File: rtl/scan_ctl4.sv
// scan_ctl4: four-digit multiplexed seven-segment scan controller.
// A slow, asynchronous scan_clk is synchronized into a one-cycle tick. On
// each tick the controller steps to the next digit, with a dark blanking
// gap between digits to prevent ghosting. Digit values are captured at
// frame start, so a frame never shows a mix of old and new values.
module scan_ctl4 #(
    parameter int BLANK_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_clk,
    input  logic       en,
    input  logic       lz_sup,
    input  logic [3:0] dig0,
    input  logic [3:0] dig1,
    input  logic [3:0] dig2,
    input  logic [3:0] dig3,
    input  logic [3:0] dp,
    output logic [3:0] ssd_ctl,
    output logic [7:0] segs,
    output logic [1:0] digit_idx,
    output logic       frame_done
);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYC - 1);

    state_t           state;
    logic [7:0]       blank_cnt;
    logic [3:0][3:0]  f_dig;
    logic [3:0]       f_dp;
    logic             f_lz;

    logic sync1, sync2, sync3;
    logic vld1, vld2, armed;
    logic tick;

    logic [3:0] lead_zero;
    logic [6:0] cur_abcg;
    logic [7:0] cur_segs;

    // Synchronizer and rising-edge detector. The armed flag only allows
    // ticks once a genuine low sample of scan_clk has been seen after reset,
    // so a scan_clk that is already high at release does not fire a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            vld1  <= 1'b0;
            vld2  <= 1'b0;
            armed <= 1'b0;
            tick  <= 1'b0;
        end else begin
            sync1 <= scan_clk;
            sync2 <= sync1;
            sync3 <= sync2;
            vld1  <= 1'b1;
            vld2  <= vld1;
            armed <= armed | (vld2 & ~sync2);
            tick  <= sync2 & ~sync3 & armed;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111110;
        endcase
    endfunction

    // Segment pattern for the current digit from the frame registers,
    // with leading-zero blanking; digit 0 is never blanked.
    always_comb begin
        lead_zero    = 4'b0000;
        lead_zero[3] = (f_dig[3] == 4'd0);
        lead_zero[2] = lead_zero[3] && (f_dig[2] == 4'd0);
        lead_zero[1] = lead_zero[2] && (f_dig[1] == 4'd0);
        if (f_lz && lead_zero[digit_idx])
            cur_abcg = 7'b1111111;
        else
            cur_abcg = seg7(f_dig[digit_idx]);
        cur_segs = {cur_abcg, ~f_dp[digit_idx]};
    end

    // Scan FSM with registered outputs; en low always wins and aborts the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ssd_ctl    <= 4'hF;
            segs       <= 8'hFF;
            digit_idx  <= 2'd0;
            frame_done <= 1'b0;
            blank_cnt  <= 8'd0;
            f_dig      <= '0;
            f_dp       <= 4'h0;
            f_lz       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!en) begin
                state     <= IDLE;
                ssd_ctl   <= 4'hF;
                segs      <= 8'hFF;
                digit_idx <= 2'd0;
                blank_cnt <= 8'd0;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= BLANK;
                        digit_idx <= 2'd0;
                        blank_cnt <= 8'd0;
                        f_dig     <= {dig3, dig2, dig1, dig0};
                        f_dp      <= dp;
                        f_lz      <= lz_sup;
                    end
                    BLANK: begin
                        if (blank_cnt == BLANK_LAST) begin
                            state     <= SHOW;
                            blank_cnt <= 8'd0;
                            ssd_ctl   <= ~(4'b0001 << digit_idx);
                            segs      <= cur_segs;
                        end else begin
                            blank_cnt <= blank_cnt + 8'd1;
                        end
                    end
                    SHOW: begin
                        if (tick) begin
                            state     <= BLANK;
                            ssd_ctl   <= 4'hF;
                            segs      <= 8'hFF;
                            blank_cnt <= 8'd0;
                            digit_idx <= digit_idx + 2'd1;
                            if (digit_idx == 2'd3) begin
                                frame_done <= 1'b1;
                                f_dig      <= {dig3, dig2, dig1, dig0};
                                f_dp       <= dp;
                                f_lz       <= lz_sup;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scan_ctl4.sv
// Directed bench for scan_ctl4: a scoreboard queue holds the expected
// {ssd_ctl, segs, digit_idx} for each digit display, popped whenever the
// DUT lights a new digit; timing and idle behaviour are checked inline.
module tb_scan_ctl4;

    logic       clk = 1'b0;
    logic       rst;
    logic       scan_clk;
    logic       en;
    logic       lz_sup;
    logic [3:0] dig0, dig1, dig2, dig3, dp;
    logic [3:0] ssd_ctl;
    logic [7:0] segs;
    logic [1:0] digit_idx;
    logic       frame_done;

    int total = 0;
    int bad   = 0;
    int fd_cnt = 0;
    int fd_save;

    typedef struct packed {
        logic [3:0] ctl;
        logic [7:0] sg;
        logic [1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    logic [3:0] prev_ctl = 4'hF;

    scan_ctl4 dut (
        .clk(clk), .rst(rst), .scan_clk(scan_clk), .en(en), .lz_sup(lz_sup),
        .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3), .dp(dp),
        .ssd_ctl(ssd_ctl), .segs(segs), .digit_idx(digit_idx),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [3:0] c, input logic [7:0] s, input logic [1:0] i);
        exp_t e;
        e.ctl = c; e.sg = s; e.idx = i;
        exp_q.push_back(e);
    endtask

    // Scoreboard: compare each newly lit digit with the next expected entry.
    always @(negedge clk) begin
        if (!rst && ssd_ctl != 4'hF && prev_ctl == 4'hF) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_display: observed=%0h/%0h expected=none", ssd_ctl, segs);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("disp_ctl", 32'(ssd_ctl), 32'(e.ctl));
                check("disp_segs", 32'(segs), 32'(e.sg));
                check("disp_idx", 32'(digit_idx), 32'(e.idx));
            end
        end
        prev_ctl <= ssd_ctl;
    end

    // Count frame_done high cycles.
    always @(negedge clk) begin
        if (!rst && frame_done) fd_cnt++;
    end

    task automatic wait_show;
        int n = 0;
        while (ssd_ctl == 4'hF && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (ssd_ctl == 4'hF) begin
            total++;
            bad++;
            $error("FAIL show_timeout: observed=dark expected=digit lit");
        end
    endtask

    // One scan_clk rising edge whose tick lands while a digit is shown.
    task automatic do_tick;
        wait_show();
        scan_clk = 1'b0;
        repeat (4) @(negedge clk);
        scan_clk = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    // Two edges two cycles apart: the second tick falls inside BLANK.
    task automatic double_edge;
        wait_show();
        scan_clk = 1'b0;
        repeat (4) @(negedge clk);
        scan_clk = 1'b1;
        @(negedge clk);
        scan_clk = 1'b0;
        @(negedge clk);
        scan_clk = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; lz_sup = 1'b0; scan_clk = 1'b0;
        dig3 = 4'd1; dig2 = 4'd2; dig1 = 4'd3; dig0 = 4'd4; dp = 4'b0000;

        // Reset with en high and scan_clk toggling: outputs stay dark.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            scan_clk = ~scan_clk;
            check("rst_ctl", 32'(ssd_ctl), 32'hF);
            check("rst_segs", 32'(segs), 32'hFF);
        end
        scan_clk = 1'b1;
        check("rst_idx", 32'(digit_idx), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);

        push(4'hE, 8'h99, 2'd0);
        push(4'hD, 8'h0D, 2'd1);
        push(4'hB, 8'h25, 2'd2);
        push(4'h7, 8'h9F, 2'd3);
        push(4'hE, 8'h99, 2'd0);

        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("blank_ctl", 32'(ssd_ctl), 32'hF);
        end
        @(negedge clk);
        check("first_show_ctl", 32'(ssd_ctl), 32'hE);

        // scan_clk high at release must not produce a tick.
        repeat (10) @(negedge clk);
        check("no_tick_after_rst", 32'(ssd_ctl), 32'hE);

        // Frame 1: step through all four digits.
        repeat (4) do_tick();
        wait_show();
        check("wrap_idx", 32'(digit_idx), 32'd0);
        check("fd_once", 32'(fd_cnt), 32'd1);

        // New values mid-frame: frame 2 keeps the old latch.
        lz_sup = 1'b1; dig3 = 4'd0; dig2 = 4'd0; dig1 = 4'd0; dig0 = 4'd7; dp = 4'b0100;
        push(4'hD, 8'h0D, 2'd1);
        push(4'hB, 8'h25, 2'd2);
        push(4'h7, 8'h9F, 2'd3);
        push(4'hE, 8'h1F, 2'd0);
        push(4'hD, 8'hFF, 2'd1);
        push(4'hB, 8'hFE, 2'd2);
        push(4'h7, 8'hFF, 2'd3);
        repeat (7) do_tick();

        // Frame 4: dash on digit 0, then a dig1 change that must not show.
        wait_show();
        lz_sup = 1'b0; dig0 = 4'hC; dp = 4'b0000;
        push(4'hE, 8'hFD, 2'd0);
        do_tick();
        wait_show();
        dig1 = 4'd5;
        push(4'hD, 8'h03, 2'd1);
        do_tick();

        // Tick landing in BLANK is dropped: digit 2 next, not digit 3.
        push(4'hB, 8'h03, 2'd2);
        double_edge();
        wait_show();
        check("drop_tick_idx", 32'(digit_idx), 32'd2);
        check("drop_tick_ctl", 32'(ssd_ctl), 32'hB);
        check("fd_three", 32'(fd_cnt), 32'd3);

        // Abort the frame at digit 2.
        fd_save = fd_cnt;
        en = 1'b0;
        @(negedge clk);
        check("abort_ctl", 32'(ssd_ctl), 32'hF);
        check("abort_segs", 32'(segs), 32'hFF);
        check("abort_idx", 32'(digit_idx), 32'd0);
        check("abort_fd", 32'(frame_done), 32'd0);
        dig3 = 4'd9; dig2 = 4'd8; dig1 = 4'd7; dig0 = 4'd6; dp = 4'hF;
        repeat (3) @(negedge clk);
        check("abort_no_fd", 32'(fd_cnt), 32'(fd_save));

        // Restart with a fresh latch.
        push(4'hE, 8'h40, 2'd0);
        push(4'hD, 8'h1E, 2'd1);
        en = 1'b1;
        wait_show();
        check("restart_idx", 32'(digit_idx), 32'd0);
        do_tick();
        wait_show();
        check("restart_idx1", 32'(digit_idx), 32'd1);

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
